// File: rtl/execute_pkg.sv
// Shared encodings and types for the execute stage: ALU ops, forwarding and SrcB selects,
// multiplier state, and the control bundle carried into the memory stage.
package execute_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MFHI = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_MFLO = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_SIMM = 2'b01;
  localparam logic [1:0] SRCB_UIMM = 2'b10;
  localparam logic [1:0] SRCB_LUI  = 2'b11;

  typedef enum logic {MS_IDLE, MS_BUSY} multState_t;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       jump;
    logic [1:0] memWrite;
  } memCtrl_t;

  // Select code 11 is unused by the hazard unit and falls back to the register value.
  function automatic logic [31:0] fwdMux(input logic [1:0] sel, input logic [31:0] regVal,
                                         input logic [31:0] resultW, input logic [31:0] aluOutM);
    case (sel)
      FWD_WB:  return resultW;
      FWD_MEM: return aluOutM;
      default: return regVal;
    endcase
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Shift-add multiplier, one bit per cycle: operands captured on the start edge, hi/lo and a
// one-cycle done pulse 32 edges later. No backpressure; start is ignored while busy.
module mult_seq
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  multState_t  state, stateNext;
  logic [4:0]  iterCnt;
  logic [31:0] mcand;
  logic [64:0] prod;
  logic        negRes;
  logic [31:0] absA, absB;
  logic [32:0] sumHi;
  logic [64:0] prodNext;
  logic [63:0] result;
  logic        lastIter;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MS_IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      MS_IDLE: if (start) stateNext = MS_BUSY;
      MS_BUSY: if (lastIter) stateNext = MS_IDLE;
      default: stateNext = MS_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MS_BUSY);
  end

  // Signed mode multiplies magnitudes and restores the sign at the final step.
  assign absA     = (sgn && a[31]) ? (~a + 32'd1) : a;
  assign absB     = (sgn && b[31]) ? (~b + 32'd1) : b;
  assign lastIter = busy && (iterCnt == 5'd31);
  assign sumHi    = prod[64:32] + {1'b0, mcand};
  assign prodNext = prod[0] ? {1'b0, sumHi, prod[31:1]} : {1'b0, prod[64:1]};
  assign result   = negRes ? (~prodNext[63:0] + 64'd1) : prodNext[63:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iterCnt <= '0;
      mcand   <= '0;
      prod    <= '0;
      negRes  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= lastIter;
      if (!busy && start) begin
        mcand   <= absA;
        prod    <= {33'd0, absB};
        negRes  <= sgn & (a[31] ^ b[31]);
        iterCnt <= '0;
      end else if (busy) begin
        prod    <= prodNext;
        iterCnt <= iterCnt + 5'd1;
        if (lastIter) {hi, lo} <= result;
      end
    end
  end

endmodule

// File: rtl/execute.sv
// Execute stage: forwarding muxes and ALU are combinational; control to the memory stage is
// one register deep. No backpressure; the multiplier runs in the background via mult_seq.
module execute
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  forwardAE,
  input  logic [1:0]  forwardBE,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ResultW,
  input  logic        RegWriteE,
  input  logic        MemToRegE,
  input  logic        jumpE,
  input  logic [1:0]  MemWriteE,
  input  logic [1:0]  ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic        RegDstE,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic        MultStartE,
  input  logic        MultSgnE,
  input  logic [31:0] SignImmE,
  input  logic [31:0] UnsignedImmE,
  output logic        RegWriteM,
  output logic        MemToRegM,
  output logic        jumpM,
  output logic        MultComplete,
  output logic [1:0]  MemWriteM,
  output logic [4:0]  WriteRegE,
  output logic [31:0] WriteDataE,
  output logic [31:0] ALUOutE
);

  logic [31:0] srcA, srcB, hiReg, loReg;
  logic        multBusy;
  memCtrl_t    ctrlE, ctrlM;
  logic        unusedRs;

  // RsE is only consumed by the hazard unit upstream.
  assign unusedRs = ^RsE;

  assign srcA       = fwdMux(forwardAE, rd1, ResultW, ALUOutM);
  assign WriteDataE = fwdMux(forwardBE, rd2, ResultW, ALUOutM);
  assign WriteRegE  = RegDstE ? RdE : RtE;

  always_comb begin
    srcB = WriteDataE;
    case (ALUSrcE)
      SRCB_SIMM: srcB = SignImmE;
      SRCB_UIMM: srcB = UnsignedImmE;
      SRCB_LUI:  srcB = {UnsignedImmE[15:0], 16'h0000};
      default:   srcB = WriteDataE;
    endcase
  end

  always_comb begin
    ALUOutE = '0;
    case (ALUControlE)
      ALU_AND:  ALUOutE = srcA & srcB;
      ALU_OR:   ALUOutE = srcA | srcB;
      ALU_ADD:  ALUOutE = srcA + srcB;
      ALU_SUB:  ALUOutE = srcA - srcB;
      ALU_SLT:  ALUOutE = {31'd0, $signed(srcA) < $signed(srcB)};
      ALU_NOR:  ALUOutE = ~(srcA | srcB);
      ALU_MFHI: ALUOutE = hiReg;
      ALU_MFLO: ALUOutE = loReg;
      default:  ALUOutE = '0;
    endcase
  end

  assign ctrlE = '{regWrite: RegWriteE, memToReg: MemToRegE, jump: jumpE, memWrite: MemWriteE};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctrlM <= '0;
    else      ctrlM <= ctrlE;
  end

  assign RegWriteM = ctrlM.regWrite;
  assign MemToRegM = ctrlM.memToReg;
  assign jumpM     = ctrlM.jump;
  assign MemWriteM = ctrlM.memWrite;

  mult_seq uMult (
    .clk   (clk),
    .rst   (rst),
    .start (MultStartE),
    .sgn   (MultSgnE),
    .a     (srcA),
    .b     (srcB),
    .hi    (hiReg),
    .lo    (loReg),
    .busy  (multBusy),
    .done  (MultComplete)
  );

endmodule

// File: tb/tb_execute.sv
// Directed bench for execute: expected values are queued when stimulus is applied and
// popped against the DUT outputs when they are sampled.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  forwardAE, forwardBE, MemWriteE, ALUSrcE, MemWriteM;
  logic [31:0] rd1, rd2, ALUOutM, ResultW, SignImmE, UnsignedImmE;
  logic        RegWriteE, MemToRegE, jumpE, RegDstE, MultStartE, MultSgnE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RsE, RtE, RdE, WriteRegE;
  logic        RegWriteM, MemToRegM, jumpM, MultComplete;
  logic [31:0] WriteDataE, ALUOutE;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  logic sawComplete;

  always #5 clk = ~clk;

  execute dut (
    .clk(clk), .rst(rst), .forwardAE(forwardAE), .forwardBE(forwardBE), .rd1(rd1), .rd2(rd2),
    .ALUOutM(ALUOutM), .ResultW(ResultW), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
    .jumpE(jumpE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RegDstE(RegDstE), .RsE(RsE), .RtE(RtE), .RdE(RdE), .MultStartE(MultStartE),
    .MultSgnE(MultSgnE), .SignImmE(SignImmE), .UnsignedImmE(UnsignedImmE),
    .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .jumpM(jumpM), .MultComplete(MultComplete),
    .MemWriteM(MemWriteM), .WriteRegE(WriteRegE), .WriteDataE(WriteDataE), .ALUOutE(ALUOutE)
  );

  task automatic pushExp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    exp_t e;
    totalCnt++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h with no expected value queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) passCnt++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
  endtask

  task automatic startMult(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    rd1 = a; rd2 = b; forwardAE = 2'b00; forwardBE = 2'b00; ALUSrcE = 2'b00;
    MultSgnE = sgn; MultStartE = 1'b1;
    @(posedge clk);
    #1 MultStartE = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    forwardAE = '0; forwardBE = '0; rd1 = '0; rd2 = '0; ALUOutM = '0; ResultW = '0;
    RegWriteE = 0; MemToRegE = 0; jumpE = 0; MemWriteE = '0; ALUSrcE = '0; ALUControlE = 3'b011;
    RegDstE = 0; RsE = 5'd1; RtE = 5'd2; RdE = 5'd3; MultStartE = 0; MultSgnE = 0;
    SignImmE = '0; UnsignedImmE = '0;

    // Reset state
    #1;
    pushExp("rst_RegWriteM", 32'd0);    popCheck({31'd0, RegWriteM});
    pushExp("rst_MemWriteM", 32'd0);    popCheck({30'd0, MemWriteM});
    pushExp("rst_MultComplete", 32'd0); popCheck({31'd0, MultComplete});
    pushExp("rst_HI", 32'd0);           popCheck(ALUOutE);
    @(negedge clk); rst = 1'b1;

    // ALU / forwarding / SrcB selection
    @(negedge clk);
    rd1 = 32'd7; rd2 = 32'd5; ALUControlE = 3'b010;
    pushExp("add_ALUOut", 32'd12); pushExp("add_WriteData", 32'd5);
    #1 popCheck(ALUOutE); popCheck(WriteDataE);

    forwardAE = 2'b10; ALUOutM = 32'd100; ALUControlE = 3'b110;
    pushExp("sub_fwdA_mem", 32'd95);
    #1 popCheck(ALUOutE);
    forwardBE = 2'b01; ResultW = 32'd200;
    pushExp("fwdB_wb", 32'd200);
    #1 popCheck(WriteDataE);

    forwardAE = 2'b11; forwardBE = 2'b11; ALUControlE = 3'b000;
    rd1 = 32'hF0F0_1234; rd2 = 32'h0FF0_FF00;
    pushExp("and_fwd11", 32'h00F0_1200);
    #1 popCheck(ALUOutE);
    forwardAE = 2'b00; forwardBE = 2'b00;
    ALUControlE = 3'b001; pushExp("or", 32'hFFF0_FF34);
    #1 popCheck(ALUOutE);
    ALUControlE = 3'b100; pushExp("nor", 32'h000F_00CB);
    #1 popCheck(ALUOutE);

    rd1 = 32'hFFFF_FFFF; rd2 = 32'd1; ALUControlE = 3'b111;
    pushExp("slt_neg", 32'd1);
    #1 popCheck(ALUOutE);
    rd1 = 32'd1; rd2 = 32'hFFFF_FFFF;
    pushExp("slt_pos", 32'd0);
    #1 popCheck(ALUOutE);

    rd1 = 32'd0; ALUSrcE = 2'b11; UnsignedImmE = 32'h0000_1234; ALUControlE = 3'b010;
    pushExp("lui", 32'h1234_0000);
    #1 popCheck(ALUOutE);
    rd1 = 32'hFFFF_FFFF; ALUSrcE = 2'b10;
    pushExp("add_wrap_uimm", 32'h0000_1233);
    #1 popCheck(ALUOutE);
    rd1 = 32'd10; ALUSrcE = 2'b01; SignImmE = 32'hFFFF_FFFC;
    pushExp("add_simm", 32'd6);
    #1 popCheck(ALUOutE);

    RegDstE = 1'b1; pushExp("wreg_rd", 32'd3);
    #1 popCheck({27'd0, WriteRegE});
    RegDstE = 1'b0; pushExp("wreg_rt", 32'd2);
    #1 popCheck({27'd0, WriteRegE});

    // Pipeline registers
    RegWriteE = 1; MemToRegE = 1; jumpE = 1; MemWriteE = 2'b01;
    pushExp("pipe_ctrl", 32'h1D);
    @(posedge clk); #1 popCheck({27'd0, RegWriteM, MemToRegM, jumpM, MemWriteM});
    MemToRegE = 0; jumpE = 0; MemWriteE = 2'b11;
    pushExp("pipe_ctrl2", 32'h13);
    @(posedge clk); #1 popCheck({27'd0, RegWriteM, MemToRegM, jumpM, MemWriteM});

    // Unsigned 7*5 with operand changes and a stray start while busy
    ALUSrcE = 2'b00;
    startMult(32'd7, 32'd5, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (i == 1) rd1 = 32'd9;
      if (i == 5) begin MultStartE = 1'b1; rd1 = 32'd3; end
      if (i == 6) MultStartE = 1'b0;
      if (i == 31) begin pushExp("mul_done_early", 32'd0); popCheck({31'd0, MultComplete}); end
    end
    pushExp("mul_done", 32'd1); popCheck({31'd0, MultComplete});
    ALUControlE = 3'b101; pushExp("mul_lo", 32'd35);
    #1 popCheck(ALUOutE);
    ALUControlE = 3'b011; pushExp("mul_hi", 32'd0);
    #1 popCheck(ALUOutE);
    @(posedge clk); #1;
    pushExp("mul_done_drop", 32'd0); popCheck({31'd0, MultComplete});

    // Signed -7*5
    startMult(32'hFFFF_FFF9, 32'd5, 1'b1);
    repeat (32) @(posedge clk);
    #1 ALUControlE = 3'b101; pushExp("smul_lo", 32'hFFFF_FFDD);
    #1 popCheck(ALUOutE);
    ALUControlE = 3'b011; pushExp("smul_hi", 32'hFFFF_FFFF);
    #1 popCheck(ALUOutE);

    // Unsigned 0xFFFFFFFF*2
    startMult(32'hFFFF_FFFF, 32'd2, 1'b0);
    repeat (32) @(posedge clk);
    #1 ALUControlE = 3'b101; pushExp("umul_lo", 32'hFFFF_FFFE);
    #1 popCheck(ALUOutE);
    ALUControlE = 3'b011; pushExp("umul_hi", 32'd1);
    #1 popCheck(ALUOutE);

    // Reset mid-multiply
    startMult(32'd7, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    pushExp("arst_done", 32'd0);     popCheck({31'd0, MultComplete});
    pushExp("arst_hi", 32'd0);       popCheck(ALUOutE);
    pushExp("arst_regwrite", 32'd0); popCheck({31'd0, RegWriteM});
    RegWriteE = 1; MemWriteE = 2'b10;
    @(negedge clk); rst = 1'b1;
    pushExp("post_rst_ctrl", 32'h6);
    @(posedge clk); #1 popCheck({29'd0, RegWriteM, MemWriteM});
    sawComplete = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (MultComplete) sawComplete = 1'b1;
    end
    pushExp("abort_no_done", 32'd0); popCheck({31'd0, sawComplete});
    ALUControlE = 3'b101; pushExp("abort_lo", 32'd0);
    #1 popCheck(ALUOutE);

    if (sb.size() != 0) begin
      totalCnt++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have exactly one clock, clk; reset is asynchronous and active-low, named rst.
REQ-002 Port list: clk in 1 clock; rst in 1 async active-low reset.
REQ-003 Data inputs: forwardAE, forwardBE in 2 each; rd1, rd2, ALUOutM, ResultW in 32 each.
REQ-004 Control inputs: RegWriteE, MemToRegE, jumpE in 1 each; MemWriteE in 2; ALUSrcE in 2; ALUControlE in 3; RegDstE in 1.
REQ-005 Operand inputs: RsE, RtE, RdE in 5 each; MultStartE, MultSgnE in 1 each; SignImmE, UnsignedImmE in 32 each, already extended upstream.
REQ-006 Outputs: RegWriteM, MemToRegM, jumpM, MultComplete out 1 each; MemWriteM out 2; WriteRegE out 5; WriteDataE, ALUOutE out 32 each.

Function
REQ-007 SrcAE SHALL be rd1 when forwardAE=00, ResultW when 01, ALUOutM when 10; 11 behaves as 00.
REQ-008 WriteDataE SHALL be the same mux applied to rd2 under forwardBE; combinational.
REQ-009 SrcBE SHALL be WriteDataE for ALUSrcE=00, SignImmE for 01, UnsignedImmE for 10, and {UnsignedImmE[15:0],16'h0} (LUI) for 11.
REQ-010 ALUOutE SHALL be combinational: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT signed (1/0), 100 NOR, 011 HI register, 101 LO register.
REQ-011 ADD/SUB SHALL wrap modulo 2^32; no overflow output.
REQ-012 WriteRegE SHALL be RdE when RegDstE=1, else RtE; combinational.
REQ-013 On each rising clk, RegWriteM, MemToRegM, jumpM, MemWriteM SHALL register RegWriteE, MemToRegE, jumpE, MemWriteE.
REQ-014 Multiplier: idle and MultStartE=1 at edge N SHALL capture SrcAE, SrcBE, MultSgnE, and go busy.
REQ-015 Multiply SHALL be iterative, one bit per cycle, 32 iterations; HI/LO take the 64-bit product on edge N+32.
REQ-016 MultComplete SHALL be high for exactly the one cycle following edge N+32, then return low.
REQ-017 MultSgnE=1 SHALL give the signed two's-complement product; 0 SHALL give unsigned.
REQ-018 MultStartE while busy SHALL be ignored; a held MultStartE restarts on the first idle edge after completion.
REQ-019 HI/LO SHALL hold their value until the next completion.
REQ-020 Operand changes during busy SHALL NOT affect the running product.

Reset
REQ-021 rst=0 SHALL immediately clear RegWriteM, MemToRegM, jumpM, MemWriteM, MultComplete, HI, LO, and multiplier state to 0/idle, independent of clk.
REQ-022 Reset mid-multiply SHALL abort it: no MultComplete, HI/LO=0.
REQ-023 After rst rises, the first rising clk SHALL behave as normal operation.

Structure
REQ-024 Shared package SHALL hold ALUControl codes, forward-select codes, and ALUSrc codes.
REQ-025 Multiplier SHALL be one sub-module, mult_seq (clk, rst, start, sgn, a, b -> hi, lo, busy, done); ALU, muxes and pipeline registers stay in execute.
REQ-026 Implementation SHALL be 120-400 RTL lines; no latches; combinational paths fully specified.

Verification
REQ-027 rd1=7, rd2=5, forward=00, ALUSrcE=00, ALUControlE=010 -> ALUOutE=12, WriteDataE=5.
REQ-028 forwardAE=10, ALUOutM=100, ALUControlE=110, rd2=5 -> ALUOutE=95; forwardBE=01, ResultW=200 -> WriteDataE=200.
REQ-029 rd1=0xFFFFFFFF, rd2=1, ALUControlE=111 -> ALUOutE=1; ALUSrcE=11, UnsignedImmE=0x1234, ALUControlE=010, rd1=0 -> ALUOutE=0x12340000.
REQ-030 MultStartE=1 one cycle, 7*5 unsigned -> MultComplete pulses one cycle at edge N+32; ALUControlE=101 gives 35, 011 gives 0.
REQ-031 MultSgnE=1, -7*5 -> LO=0xFFFFFFDD, HI=0xFFFFFFFF; unsigned 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
REQ-032 rst=0 at iteration 10 -> no MultComplete, HI=LO=0; RegWriteE=1, MemWriteE=10 -> RegWriteM=1, MemWriteM=10 after next edge once rst=1.
